stopwatch_ctrl: RTL

Mode controller and tick scheduler for the MM:SS stopwatch digit counter. Synchronizes and edge-detects the user buttons and switches, and runs a RUN/PAUSED/ADJUST state machine. Generates the single-cycle pulses that sequence the counter: advance one second, increment the selected digit, and clear. Also drives the digit-select pointer and blink enable for the display.

---
 rtl/stopwatch_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: mode controller and tick scheduler for an MM:SS stopwatch digit counter.
//
// Synchronizes the buttons and the adjust switch, edge-detects the buttons with a per-button
// lockout, and runs a RUN / PAUSED / ADJUST state machine. It produces single-cycle pulses that
// sequence the digit counter, plus the adjust digit pointer and the blink enable.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous, active-high reset
//   btn_pause in   async level, 1 = pressed; toggles run/pause
//   btn_reset in   async level, 1 = pressed; clears the counter
//   btn_sel   in   async level, 1 = pressed; advances the adjust digit pointer
//   sw_adj    in   async level; 1 = adjust mode requested
//   tick_run  out  one-cycle pulse: counter advances one second
//   tick_adj  out  one-cycle pulse: increment digit adj_sel
//   clr       out  one-cycle pulse: zero all digits
//   adj       out  level, 1 while in ADJUST
//   adj_sel   out  selected digit: 0 = min tens, 1 = min ones, 2 = sec tens, 3 = sec ones
//   paused    out  level, 1 while in PAUSED
//   blink     out  1 = blank the selected digit; 0 outside ADJUST
module stopwatch_ctrl #(
  parameter int unsigned DIV_1HZ   = 100000000,
  parameter int unsigned DIV_ADJ   = 50000000,
  parameter int unsigned DIV_BLINK = 25000000,
  parameter int unsigned LOCKOUT   = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_pause,
  input  logic       btn_reset,
  input  logic       btn_sel,
  input  logic       sw_adj,
  output logic       tick_run,
  output logic       tick_adj,
  output logic       clr,
  output logic       adj,
  output logic [1:0] adj_sel,
  output logic       paused,
  output logic       blink
);

  localparam int unsigned RunW   = $clog2(DIV_1HZ);
  localparam int unsigned AdjW   = $clog2(DIV_ADJ);
  localparam int unsigned BlinkW = $clog2(DIV_BLINK);
  localparam int unsigned LockW  = (LOCKOUT > 1) ? $clog2(LOCKOUT) : 1;

  localparam logic [RunW-1:0]   RunMax   = RunW'(DIV_1HZ - 1);
  localparam logic [AdjW-1:0]   AdjMax   = AdjW'(DIV_ADJ - 1);
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(DIV_BLINK - 1);
  localparam logic [LockW-1:0]  LockLoad = LockW'((LOCKOUT > 0) ? LOCKOUT - 1 : 0);

  localparam int BtnPause = 0;
  localparam int BtnReset = 1;
  localparam int BtnSel   = 2;

  typedef enum logic [1:0] {StRun, StPaused, StAdjust} state_e;

  // Input path: bit 3 is sw_adj, bits 2:0 are the buttons.
  logic [3:0]            sync1_q, sync2_q;
  logic [2:0]            prev_q, edge_q, armed_q;
  logic [1:0]            fill_q;
  logic                  adj_lvl_q;
  logic [2:0][LockW-1:0] lock_q, lock_d;
  logic [2:0]            accept;

  state_e             state_q, state_d;
  logic [RunW-1:0]    run_cnt_q, run_cnt_d;
  logic [AdjW-1:0]    adj_cnt_q, adj_cnt_d;
  logic [BlinkW-1:0]  blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;
  logic [1:0]         adj_sel_q, adj_sel_d;
  logic               tick_run_q, tick_adj_q, clr_q, adj_q, paused_q;
  logic               pause_acc, reset_acc, sel_acc, stay_adj, sel_act;

  always_comb begin
    accept = '0;
    lock_d = lock_q;
    for (int i = 0; i < 3; i++) begin
      accept[i] = edge_q[i] && (lock_q[i] == '0);
      if (accept[i]) begin
        lock_d[i] = LockLoad;
      end else if (lock_q[i] != '0) begin
        lock_d[i] = lock_q[i] - LockW'(1);
      end
    end
    pause_acc = accept[BtnPause];
    reset_acc = accept[BtnReset];
    sel_acc   = accept[BtnSel];

    // sw_adj outranks pause; the reset button never changes state.
    state_d = state_q;
    if (adj_lvl_q) begin
      state_d = StAdjust;
    end else begin
      unique case (state_q)
        StRun:    if (pause_acc) state_d = StPaused;
        StPaused: if (pause_acc) state_d = StRun;
        StAdjust: state_d = StPaused;
        default:  state_d = StRun;
      endcase
    end

    stay_adj  = (state_q == StAdjust) && (state_d == StAdjust);
    sel_act   = stay_adj && sel_acc;
    adj_sel_d = adj_sel_q + 2'(sel_act);

    // Run prescaler holds while paused so the fractional second survives a pause.
    run_cnt_d = run_cnt_q;
    if (clr_q || ((state_d == StAdjust) && (state_q != StAdjust))) begin
      run_cnt_d = '0;
    end else if (state_q == StRun) begin
      run_cnt_d = (run_cnt_q == RunMax) ? '0 : run_cnt_q + RunW'(1);
    end

    adj_cnt_d   = '0;
    blink_cnt_d = '0;
    blink_d     = 1'b0;
    if (stay_adj && !sel_act) begin
      adj_cnt_d = (adj_cnt_q == AdjMax) ? '0 : adj_cnt_q + AdjW'(1);
      if (blink_cnt_q == BlinkMax) begin
        blink_d = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BlinkW'(1);
        blink_d     = blink_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      prev_q      <= '0;
      edge_q      <= '0;
      armed_q     <= '0;
      fill_q      <= '0;
      adj_lvl_q   <= 1'b0;
      lock_q      <= '0;
      state_q     <= StRun;
      run_cnt_q   <= '0;
      adj_cnt_q   <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      adj_sel_q   <= '0;
      tick_run_q  <= 1'b0;
      tick_adj_q  <= 1'b0;
      clr_q       <= 1'b0;
      adj_q       <= 1'b0;
      paused_q    <= 1'b0;
    end else begin
      sync1_q   <= {sw_adj, btn_sel, btn_reset, btn_pause};
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q[2:0];
      edge_q    <= sync2_q[2:0] & ~prev_q & armed_q;
      // The synchronizer holds reset zeros for two cycles; a button only arms once a real
      // low level has been seen, so a press held through reset yields no edge.
      fill_q    <= {fill_q[0], 1'b1};
      armed_q   <= armed_q | ({3{fill_q[1]}} & ~sync2_q[2:0]);
      adj_lvl_q <= sync2_q[3];
      lock_q    <= lock_d;

      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      adj_cnt_q   <= adj_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      adj_sel_q   <= adj_sel_d;

      // Pulses are registered from next-state values so they line up with the count they mark.
      tick_run_q <= (state_d == StRun) && (run_cnt_d == RunMax) && !reset_acc;
      tick_adj_q <= (state_d == StAdjust) && (adj_cnt_d == AdjMax);
      clr_q      <= reset_acc;
      adj_q      <= (state_d == StAdjust);
      paused_q   <= (state_d == StPaused);
    end
  end

  assign tick_run = tick_run_q;
  assign tick_adj = tick_adj_q;
  assign clr      = clr_q;
  assign adj      = adj_q;
  assign adj_sel  = adj_sel_q;
  assign paused   = paused_q;
  assign blink    = blink_q;

endmodule
